// File: rtl/ov_7670_pkg.sv
// Shared widths, camera ids and arbiter state encoding for the OV7670 frame-buffer path.
package ov_7670_pkg;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 24;
  localparam logic CAM0 = 1'b0;
  localparam logic CAM1 = 1'b1;

  typedef enum logic {
    IDLE,
    ISSUE
  } arb_state_t;
endpackage

// File: rtl/ov_7670_pix_fifo.sv
// Synchronous pixel FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module ov_7670_pix_fifo #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ov_7670_fb_arbiter.sv
// Merges two camera capture write streams into one frame-buffer write port with round-robin grant.
import ov_7670_pkg::*;

module ov_7670_fb_arbiter #(
  parameter int unsigned ADDR_W     = ov_7670_pkg::ADDR_W,
  parameter int unsigned DATA_W     = ov_7670_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cam0_addr,
  input  logic [DATA_W-1:0] cam0_data,
  input  logic              cam0_we,
  input  logic [ADDR_W-1:0] cam1_addr,
  input  logic [DATA_W-1:0] cam1_data,
  input  logic              cam1_we,
  input  logic              ovf_clr,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic              mem_wait,
  output logic              cam0_ovf,
  output logic              cam1_ovf
);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  arb_state_t       state;
  logic             last_grant;
  logic             grant;
  logic             any_ready;
  logic             pop_en;
  logic             pop0, pop1;
  logic             full0, full1;
  logic             empty0, empty1;
  logic [ENT_W-1:0] head0, head1, head;

  ov_7670_pix_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset), .push(cam0_we), .din({cam0_addr, cam0_data}),
    .pop(pop0), .dout(head0), .full(full0), .empty(empty0)
  );

  ov_7670_pix_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .push(cam1_we), .din({cam1_addr, cam1_data}),
    .pop(pop1), .dout(head1), .full(full1), .empty(empty1)
  );

  always_comb begin
    any_ready = !empty0 || !empty1;
    if (!empty0 && !empty1) grant = ~last_grant;
    else                    grant = empty0 ? CAM1 : CAM0;
    // A new head may be loaded whenever the output register is free or being accepted this cycle.
    pop_en = any_ready && ((state == IDLE) || !mem_wait);
    pop0   = pop_en && (grant == CAM0);
    pop1   = pop_en && (grant == CAM1);
    head   = (grant == CAM1) ? head1 : head0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      last_grant <= CAM1;
    end else if (pop_en) begin
      state      <= ISSUE;
      mem_we     <= 1'b1;
      mem_addr   <= {grant, head[ENT_W-1 -: ADDR_W]};
      mem_data   <= head[DATA_W-1:0];
      last_grant <= grant;
    end else if ((state == ISSUE) && !mem_wait) begin
      state  <= IDLE;
      mem_we <= 1'b0;
    end
  end

  // A dropped write takes priority over a simultaneous clear so the loss is never hidden.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cam0_ovf <= 1'b0;
      cam1_ovf <= 1'b0;
    end else begin
      if (cam0_we && full0 && !pop0) cam0_ovf <= 1'b1;
      else if (ovf_clr)              cam0_ovf <= 1'b0;
      if (cam1_we && full1 && !pop1) cam1_ovf <= 1'b1;
      else if (ovf_clr)              cam1_ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ov_7670_fb_arbiter.sv
// Directed scoreboard bench for the dual-camera frame-buffer arbiter.
module tb_ov_7670_fb_arbiter;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 24;
  localparam int unsigned EW = AW + 1 + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cam0_addr, cam1_addr;
  logic [DW-1:0] cam0_data, cam1_data;
  logic          cam0_we, cam1_we, ovf_clr;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we, mem_wait;
  logic          cam0_ovf, cam1_ovf;

  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            acc_cnt = 0;
  bit            mon_en = 1'b1;

  ov_7670_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cam0_addr(cam0_addr), .cam0_data(cam0_data), .cam0_we(cam0_we),
    .cam1_addr(cam1_addr), .cam1_data(cam1_data), .cam1_we(cam1_we),
    .ovf_clr(ovf_clr), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_wait(mem_wait), .cam0_ovf(cam0_ovf), .cam1_ovf(cam1_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input logic cam, input int a);
    logic [31:0] av;
    av = a;
    return {cam ? 8'hB1 : 8'hA0, av[15:0]};
  endfunction

  function automatic logic [EW-1:0] ent(input logic cam, input int a);
    logic [31:0] av;
    av = a;
    return {cam, av[AW-1:0], dat(cam, a)};
  endfunction

  // Scoreboard: every cycle mem_we is high the port must show the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && !reset && mem_we) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed %h expected none", {mem_addr, mem_data});
      end
      if (exp_q.size() != 0) begin
        chk("mem_write", {mem_addr, mem_data}, exp_q[0]);
        if (!mem_wait) begin
          void'(exp_q.pop_front());
          acc_cnt++;
        end
      end else if (!mem_wait) begin
        acc_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    int l0[$];
    int l1[$];
    reset = 1'b1; mem_wait = 1'b0; ovf_clr = 1'b0;
    cam0_we = 1'b0; cam1_we = 1'b0;
    cam0_addr = '0; cam1_addr = '0; cam0_data = '0; cam1_data = '0;

    #3;
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_data", 64'(mem_data), 64'd0);
    chk("rst_ovf", {62'd0, cam0_ovf, cam1_ovf}, 64'd0);
    @(negedge clk) reset = 1'b0;
    step();

    // Single write, minimum latency, single-cycle strobe
    cam0_addr = 19'd5; cam0_data = 24'hABCDEF; cam0_we = 1'b1;
    exp_q.push_back({1'b0, 19'd5, 24'hABCDEF});
    step();
    cam0_we = 1'b0;
    @(negedge clk) chk("lat_before", 64'(mem_we), 64'd0);
    @(negedge clk) chk("lat_we", 64'(mem_we), 64'd1);
    chk("lat_addr", 64'(mem_addr), 64'h00005);
    chk("lat_data", 64'(mem_data), 64'hABCDEF);
    @(negedge clk) chk("single_cycle", 64'(mem_we), 64'd0);
    drain("drain_single", 10);

    // Simultaneous writes from reset: cam0 wins the first tie
    do_reset();
    step();
    cam0_addr = 19'd1; cam0_data = dat(1'b0, 1); cam0_we = 1'b1;
    cam1_addr = 19'd2; cam1_data = dat(1'b1, 2); cam1_we = 1'b1;
    exp_q.push_back(ent(1'b0, 1));
    exp_q.push_back(ent(1'b1, 2));
    step();
    cam0_we = 1'b0; cam1_we = 1'b0;
    @(negedge clk);
    @(negedge clk) chk("tie_first", 64'(mem_addr), 64'h00001);
    @(negedge clk) chk("tie_second_we", 64'(mem_we), 64'd1);
    chk("tie_second", 64'(mem_addr), 64'h80002);
    drain("drain_tie", 10);

    // Ten-cycle stall holds the outputs; one accepted write after release
    mem_wait = 1'b1;
    cam0_addr = 19'd9; cam0_data = dat(1'b0, 9); cam0_we = 1'b1;
    exp_q.push_back(ent(1'b0, 9));
    step();
    cam0_we = 1'b0;
    @(negedge clk);
    a0 = acc_cnt;
    repeat (10) @(negedge clk) chk("stall_we", 64'(mem_we), 64'd1);
    @(posedge clk); #1;
    mem_wait = 1'b0;
    drain("drain_stall", 10);
    chk("stall_accepts", 64'(acc_cnt - a0), 64'd1);

    // Fill cam1 FIFO behind a stalled write, then overflow and clear
    do_reset();
    step();
    mem_wait = 1'b1;
    cam1_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cam1_addr = AW'(20 + i); cam1_data = dat(1'b1, 20 + i);
      exp_q.push_back(ent(1'b1, 20 + i));
      step();
    end
    chk("ovf_after5", 64'(cam1_ovf), 64'd0);
    cam1_addr = 19'd25; cam1_data = dat(1'b1, 25);
    step();
    cam1_we = 1'b0;
    @(negedge clk) chk("ovf_set", 64'(cam1_ovf), 64'd1);
    chk("ovf_other", 64'(cam0_ovf), 64'd0);
    step();
    cam1_addr = 19'd26; cam1_data = dat(1'b1, 26); cam1_we = 1'b1; ovf_clr = 1'b1;
    step();
    cam1_we = 1'b0; ovf_clr = 1'b0;
    @(negedge clk) chk("ovf_prio", 64'(cam1_ovf), 64'd1);
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    @(negedge clk) chk("ovf_clear", 64'(cam1_ovf), 64'd0);
    step();
    mem_wait = 1'b0;
    drain("drain_ovf", 20);

    // Saturation: both cameras every cycle, strict alternation, drops only once full
    do_reset();
    step();
    for (int k = 1; k <= 20; k++) begin
      if (k <= 8 || (k % 2) == 0) l0.push_back(k);
      if (k <= 7 || (k % 2) == 1) l1.push_back(k);
    end
    for (int i = 0; i < l0.size(); i++) begin
      exp_q.push_back(ent(1'b0, l0[i]));
      if (i < l1.size()) exp_q.push_back(ent(1'b1, l1[i]));
    end
    cam0_we = 1'b1; cam1_we = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cam0_addr = AW'(k); cam0_data = dat(1'b0, k);
      cam1_addr = AW'(k); cam1_data = dat(1'b1, k);
      step();
    end
    cam0_we = 1'b0; cam1_we = 1'b0;
    drain("drain_sat", 80);
    chk("sat_ovf0", 64'(cam0_ovf), 64'd1);
    chk("sat_ovf1", 64'(cam1_ovf), 64'd1);

    // Asynchronous reset with queued and in-flight writes discards them all
    do_reset();
    step();
    mon_en = 1'b0;
    mem_wait = 1'b1;
    cam0_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cam0_addr = AW'(40 + k); cam0_data = dat(1'b0, 40 + k);
      step();
    end
    cam0_we = 1'b0;
    @(negedge clk) chk("pre_rst_we", 64'(mem_we), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_we", 64'(mem_we), 64'd0);
    chk("async_rst_addr", 64'(mem_addr), 64'd0);
    @(negedge clk) reset = 1'b0;
    step();
    mem_wait = 1'b0;
    mon_en = 1'b1;
    a0 = acc_cnt;
    repeat (10) step();
    chk("no_replay", 64'(acc_cnt - a0), 64'd0);
    chk("idle_after_rst", 64'(mem_we), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
